mux_rr_arbiter: RTL and testbench

Round-robin controller for a shared N:1 data multiplexer: arbitrates N burst requesters, drives the mux select, and forwards the granted requester's valid/ready stream to a single downstream consumer. A grant is held for a whole burst (until `last` or a beat cap), then released and re-arbitrated. It sits in front of any shared mux-tree datapath where one output resource is time-shared between several sources.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/mux_rr_pick.sv | 39 +++
 rtl/mux_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and width helper for the round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Width of a counter/index that must hold values 0..n-1; never narrower than 1 bit.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, take the lowest set bit, rotate back.
module mux_rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx,
   output logic          any
);

   localparam int SW = IW + 1;

   logic [N-1:0] rot;
   logic [SW-1:0] off;
   logic [SW-1:0] sum;

   always_comb begin
      rot  = N'({req, req} >> ptr);
      off  = '0;
      any  = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            off = SW'(j);
            any = 1'b1;
         end
      end
      // off + ptr is below 2N, so one conditional subtract is a full modulo N
      sum = off + SW'(ptr);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx  = sum[IW-1:0];
      pick = '0;
      pick[idx] = any;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Burst round-robin arbiter driving an N:1 valid/ready mux; grant held until last or beat cap.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int W         = 8,
   parameter int MAX_BURST = 16,
   parameter int IW        = clog2w(N),
   parameter int CW        = clog2w(MAX_BURST + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   input  logic [N-1:0]    in_last,
   output logic [N-1:0]    in_ready,
   output logic [W-1:0]    out_data,
   output logic            out_valid,
   output logic            out_last,
   input  logic            out_ready,
   output logic [N-1:0]    gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            busy,
   output arb_state_t      dbg_state,
   output logic [IW-1:0]   dbg_ptr,
   output logic [CW-1:0]   dbg_cnt
);

   // Handshake: a beat moves on a cycle where out_valid && out_ready; the source keeps
   // data/last stable while valid is high and ready is low. Only the granted lane sees ready.

   arb_state_t    state, state_nx;
   logic [N-1:0]  gnt_nx;
   logic [IW-1:0] idx_nx;
   logic [IW-1:0] ptr, ptr_nx;
   logic [CW-1:0] cnt, cnt_nx;

   logic [N-1:0]  pick;
   logic [IW-1:0] pick_idx;
   logic          pick_any;
   logic          xfer;
   logic          done;

   mux_rr_pick #(.N(N), .IW(IW)) u_pick (
      .req  (req),
      .ptr  (ptr),
      .pick (pick),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   always_comb begin
      out_data  = '0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      in_ready  = '0;
      if (state == BURST) begin
         out_data  = in_data[gnt_idx*W +: W];
         out_valid = in_valid[gnt_idx];
         out_last  = in_last[gnt_idx] | (cnt == CW'(MAX_BURST - 1));
         in_ready[gnt_idx] = out_ready;
      end
   end

   assign xfer = out_valid & out_ready;
   // Natural/forced last on a transfer, or the owner walked away without a pending beat
   assign done = (state == BURST) &
                 ((xfer & out_last) | (~req[gnt_idx] & ~in_valid[gnt_idx]));

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      idx_nx   = gnt_idx;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nx = BURST;
               gnt_nx   = pick;
               idx_nx   = pick_idx;
               cnt_nx   = '0;
            end
         end
         BURST: begin
            if (xfer) cnt_nx = cnt + CW'(1);
            if (done) begin
               state_nx = IDLE;
               gnt_nx   = '0;
               ptr_nx   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_idx <= '0;
         ptr     <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nx;
         gnt     <= gnt_nx;
         gnt_idx <= idx_nx;
         ptr     <= ptr_nx;
         cnt     <= cnt_nx;
      end
   end

   assign busy      = (state == BURST);
   assign dbg_state = state;
   assign dbg_ptr   = ptr;
   assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed burst scenarios plus random traffic against a behavioural model.
module tb_mux_rr_arbiter;
   import mux_arb_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;
   localparam int IW = 2;
   localparam int CW = 3;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_last;
   logic            out_ready;
   logic [N-1:0]    gnt;
   logic [IW-1:0]   gnt_idx;
   logic            busy;
   arb_state_t      dbg_state;
   logic [IW-1:0]   dbg_ptr;
   logic [CW-1:0]   dbg_cnt;

   mux_rr_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .busy      (busy),
      .dbg_state (dbg_state),
      .dbg_ptr   (dbg_ptr),
      .dbg_cnt   (dbg_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // ---------------- scoreboard / model state ----------------
   logic [W-1:0] exp_q[$];
   bit           m_busy;
   int           m_k, m_ptr, m_cnt;
   logic [W-1:0] e_data;
   bit           e_valid, e_last;
   logic [N-1:0] e_ready;

   // source drivers
   int bl[N];
   int sq[N];
   bit nolast[N];
   bit refill[N];
   bit rnd_mode;
   bit t_rst;
   bit t_ordy;

   int glog[$];
   int gcyc[$];
   bit prev_busy;
   int start;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] src_data(input int i, input int s);
      return W'(i * 37 + s * 5 + 1);
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_src();
      rst       = t_rst;
      out_ready = t_ordy;
      for (int i = 0; i < N; i++) begin
         req[i]      = (bl[i] > 0);
         in_valid[i] = (bl[i] > 0);
         in_last[i]  = (bl[i] == 1) && !nolast[i];
         in_data[i*W +: W] = src_data(i, sq[i]);
      end
   endtask

   task automatic drive_rand();
      rst       = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
         req[i]      = ($urandom_range(0, 9) < 7);
         in_valid[i] = ($urandom_range(0, 9) < 7);
         in_last[i]  = ($urandom_range(0, 3) == 0);
         in_data[i*W +: W] = W'($urandom);
      end
   endtask

   task automatic src_advance();
      for (int i = 0; i < N; i++) begin
         if (in_valid[i] && in_ready[i]) begin
            bl[i]--;
            sq[i]++;
            if (refill[i] && bl[i] == 0) bl[i] = 1;
         end
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_eval();
      e_data  = '0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_ready = '0;
      if (m_busy) begin
         e_data  = in_data[m_k*W +: W];
         e_valid = in_valid[m_k];
         e_last  = in_last[m_k] || (m_cnt == MB - 1);
         e_ready[m_k] = out_ready;
         if (e_valid && out_ready) exp_q.push_back(e_data);
      end
   endtask

   task automatic model_update();
      int  c;
      bit  x, l;
      if (rst) begin
         m_busy = 0; m_k = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_busy) begin
         for (int j = 0; j < N; j++) begin
            c = (m_ptr + j) % N;
            if (req[c]) begin
               m_busy = 1; m_k = c; m_cnt = 0;
               break;
            end
         end
      end else begin
         x = in_valid[m_k] && out_ready;
         l = in_last[m_k] || (m_cnt == MB - 1);
         if (x) m_cnt++;
         if ((x && l) || (!req[m_k] && !in_valid[m_k])) begin
            m_busy = 0;
            m_ptr  = (m_k + 1) % N;
         end
      end
   endtask

   task automatic check_all();
      check("gnt", gnt, m_busy ? 32'(1 << m_k) : 32'd0);
      check("busy", busy, m_busy);
      check("state", dbg_state, m_busy);
      check("ptr", dbg_ptr, m_ptr);
      if (m_busy) begin
         check("gnt_idx", gnt_idx, m_k);
         check("cnt", dbg_cnt, m_cnt);
      end
      check("out_valid", out_valid, e_valid);
      check("out_last", out_last, e_last);
      check("out_data", out_data, e_data);
      check("in_ready", in_ready, e_ready);
      if (out_valid && out_ready) begin
         check("sb_pending", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("sb_data", out_data, exp_q.pop_front());
      end
      if (busy && !prev_busy) begin
         glog.push_back(int'(gnt_idx));
         gcyc.push_back(cyc);
      end
      prev_busy = busy;
   endtask

   // One clock: drive at the falling edge, check mid-cycle, advance model before the rising edge.
   task automatic cycle();
      @(negedge clk);
      if (rnd_mode) drive_rand();
      else          drive_src();
      #1;
      model_eval();
      check_all();
      model_update();
      if (!rnd_mode) src_advance();
      cyc++;
   endtask

   task automatic reset_dut();
      rnd_mode = 0;
      t_rst    = 1;
      t_ordy   = 1;
      for (int i = 0; i < N; i++) begin
         bl[i] = 0; sq[i] = 0; nolast[i] = 0; refill[i] = 0;
      end
      cycle();
      cycle();
      t_rst = 0;
      @(posedge clk);
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_idx", gnt_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_ptr", dbg_ptr, 0);
      check("rst_cnt", dbg_cnt, 0);
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 0);
      glog.delete();
      gcyc.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1; req = '0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
      m_busy = 0; m_k = 0; m_ptr = 0; m_cnt = 0; prev_busy = 0;
      repeat (2) @(posedge clk);

      // single burst from requester 1
      reset_dut();
      bl[1] = 3;
      start = cyc;
      repeat (6) cycle();
      check("single_ngrants", glog.size(), 1);
      if (glog.size() > 0) begin
         check("single_who", glog[0], 1);
         check("single_lat", gcyc[0] - start, 1);
      end
      check("single_beats", sq[1], 3);
      check("single_ptr", dbg_ptr, 2);
      bl[0] = 1; bl[2] = 1;
      repeat (6) cycle();
      check("next_ngrants", glog.size(), 3);
      if (glog.size() == 3) begin
         check("next_first", glog[1], 2);
         check("next_second", glog[2], 0);
      end

      // fairness with all four requesting single beats
      reset_dut();
      for (int i = 0; i < N; i++) begin bl[i] = 1; refill[i] = 1; end
      repeat (10) cycle();
      check("fair_ngrants", 32'(glog.size() >= 5), 1);
      if (glog.size() >= 5) begin
         for (int i = 0; i < 5; i++) check("fair_order", glog[i], i % N);
         for (int i = 0; i < 4; i++) check("fair_gap", gcyc[i+1] - gcyc[i], 2);
      end

      // beat cap: 6-beat stream without last from requester 2
      reset_dut();
      bl[2] = 6; nolast[2] = 1; bl[3] = 1;
      repeat (16) cycle();
      check("cap_ngrants", glog.size(), 3);
      if (glog.size() == 3) begin
         check("cap_g0", glog[0], 2);
         check("cap_g1", glog[1], 3);
         check("cap_g2", glog[2], 2);
      end
      check("cap_beats", sq[2], 6);

      // backpressure mid-burst
      reset_dut();
      bl[0] = 4;
      repeat (3) cycle();
      t_ordy = 0;
      repeat (5) cycle();
      check("bp_cnt", dbg_cnt, 2);
      check("bp_ready", in_ready, 0);
      check("bp_gnt", gnt, 4'b0001);
      check("bp_beats", sq[0], 2);
      t_ordy = 1;
      repeat (5) cycle();
      check("bp_done", sq[0], 4);
      check("bp_idle", busy, 0);

      // abandon by requester 0
      reset_dut();
      t_ordy = 0;
      bl[0] = 3;
      cycle();
      bl[0] = 0;
      cycle();
      cycle();
      check("ab_busy", busy, 0);
      check("ab_gnt", gnt, 0);
      check("ab_ptr", dbg_ptr, 1);
      check("ab_beats", sq[0], 0);
      t_ordy = 1;

      // reset during a burst from requester 3
      reset_dut();
      bl[3] = 5;
      repeat (2) cycle();
      t_rst = 1;
      cycle();
      t_rst = 0;
      @(posedge clk);
      #1;
      check("mr_gnt", gnt, 0);
      check("mr_busy", busy, 0);
      check("mr_valid", out_valid, 0);
      check("mr_ptr", dbg_ptr, 0);
      cycle();
      @(posedge clk);
      #1;
      check("mr_regrant", gnt, 4'b1000);
      repeat (6) cycle();

      // random traffic
      reset_dut();
      rnd_mode = 1;
      repeat (3000) cycle();
      rnd_mode = 0;
      t_rst = 0;
      t_ordy = 1;
      for (int i = 0; i < N; i++) bl[i] = 0;
      repeat (3) cycle();

      check("sb_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
